pipe_adder: RTL

- Parametrised, pipelined successor to the team's 8-bit ripple adder.
- Adds two WIDTH-bit operands plus carry-in, SEG_W bits per pipeline stage, with carries rippling stage to stage.
- Valid/ready handshake on input and output, so a producer can stream one operation per cycle with backpressure.
- Produces sum, carry-out and signed-overflow flag; feeds the datapath accumulators and ALU front-end.

---
 rtl/pipe_adder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//
// Pipelined WIDTH-bit adder. Each of the NSEG pipeline stages adds one SEG_W-bit
// segment of the operands (the last segment may be narrower) plus the carry
// from the previous stage. The operands travel down the pipeline with their
// results, and the lower sum segments travel with them, so the last stage holds
// the complete result.
// Latency is NSEG register stages. A valid/ready handshake on both sides
// sustains one operation per cycle and supports backpressure.
//
// Optional build macro: PIPE_ADDER_SUB_EN
//   When defined, an extra input `sub` selects a - b, computed as a + ~b + 1.
//   In that mode cin is ignored.
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 2)
//   SEG_W  bits added per pipeline stage (1..WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set present
//   in_ready   block accepts operands this cycle (= ~stall)
//   a, b       operands, bit 0 = LSB
//   cin        carry into bit 0
//   sub        (PIPE_ADDER_SUB_EN only) 1 = subtract b from a
//   out_valid  result present
//   out_ready  consumer accepts result this cycle
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow
// -----------------------------------------------------------------------------
module pipe_adder #(
  parameter int WIDTH = 8,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;

  // Per-stage registers. b_reg holds the effective B operand, which is the
  // inverted B operand in subtract mode.
  logic             valid_reg [NSEG];
  logic [WIDTH-1:0] sum_reg   [NSEG];
  logic             carry_reg [NSEG];
  logic [WIDTH-1:0] a_reg     [NSEG];
  logic [WIDTH-1:0] b_reg     [NSEG];

  logic             valid_next [NSEG];
  logic [WIDTH-1:0] sum_next   [NSEG];
  logic             carry_next [NSEG];
  logic [WIDTH-1:0] a_next     [NSEG];
  logic [WIDTH-1:0] b_next     [NSEG];

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // The whole pipeline freezes while the output is valid and not taken.
  assign stall    = valid_reg[NSEG-1] & ~out_ready;
  assign in_ready = ~stall;

`ifdef PIPE_ADDER_SUB_EN
  // Subtraction is addition of the ones' complement with a forced carry-in.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_stage
      localparam int LO = gi * SEG_W;
      // The last segment is narrower when WIDTH is not a multiple of SEG_W.
      localparam int SW = (LO + SEG_W > WIDTH) ? (WIDTH - LO) : SEG_W;

      logic             v_src;
      logic             c_src;
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] s_src;
      logic [SW:0]      seg_add;
      logic [WIDTH-1:0] merged;

      if (gi == 0) begin : g_head
        assign v_src = in_valid;
        assign c_src = c_eff;
        assign a_src = a;
        assign b_src = b_eff;
        assign s_src = '0;
      end else begin : g_body
        assign v_src = valid_reg[gi-1];
        assign c_src = carry_reg[gi-1];
        assign a_src = a_reg[gi-1];
        assign b_src = b_reg[gi-1];
        assign s_src = sum_reg[gi-1];
      end

      assign seg_add = {1'b0, a_src[LO +: SW]} + {1'b0, b_src[LO +: SW]}
                     + {{SW{1'b0}}, c_src};

      // Splice this stage's segment into the partial sum from the stages below.
      always_comb begin
        merged           = s_src;
        merged[LO +: SW] = seg_add[SW-1:0];
      end

      assign valid_next[gi] = v_src;
      assign sum_next[gi]   = merged;
      assign carry_next[gi] = seg_add[SW];
      assign a_next[gi]     = a_src;
      assign b_next[gi]     = b_src;
    end
  endgenerate

  // Data fields load only when a valid operation arrives. Bubbles therefore
  // leave the stage contents unchanged, and the outputs keep their last
  // result while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        valid_reg[k] <= 1'b0;
        sum_reg[k]   <= '0;
        carry_reg[k] <= 1'b0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < NSEG; k++) begin
        valid_reg[k] <= valid_next[k];
        if (valid_next[k]) begin
          sum_reg[k]   <= sum_next[k];
          carry_reg[k] <= carry_next[k];
          a_reg[k]     <= a_next[k];
          b_reg[k]     <= b_next[k];
        end
      end
    end
  end

  assign out_valid = valid_reg[NSEG-1];
  assign sum       = sum_reg[NSEG-1];
  assign cout      = carry_reg[NSEG-1];
  // Signed overflow: the operand signs agree but the sign of the sum differs.
  // The effective (possibly inverted) B operand supplies the B sign.
  assign ovf       = (a_reg[NSEG-1][WIDTH-1] == b_reg[NSEG-1][WIDTH-1]) &&
                     (sum_reg[NSEG-1][WIDTH-1] != a_reg[NSEG-1][WIDTH-1]);

endmodule
